// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for the CPU MAR/MDR path and a DMA/loader port.
// Build with MEM_ARB_CPU_PRIORITY_EN for fixed CPU priority; otherwise round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              dma_req,
    input  logic              cpu_we,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              cpu_ack,
    output logic              dma_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam int              CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              owner_cpu_reg;
    logic              we_reg;
    logic              ram_en_reg;
    logic              ram_we_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_wdata_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;
    logic [DATA_W-1:0] dma_rdata_reg;
    logic              grant_cpu;
    logic              any_req;

`ifndef MEM_ARB_CPU_PRIORITY_EN
    logic              last_dma_reg;
`endif

    assign any_req = cpu_req | dma_req;

    always_comb begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
        grant_cpu = cpu_req;
`else
        // On a conflict the port that did not win last time goes first.
        grant_cpu = cpu_req && (!dma_req || last_dma_reg);
`endif
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            owner_cpu_reg <= 1'b0;
            we_reg        <= 1'b0;
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            cpu_rdata_reg <= '0;
            dma_rdata_reg <= '0;
`ifndef MEM_ARB_CPU_PRIORITY_EN
            last_dma_reg  <= 1'b1;
`endif
        end else begin
            ram_en_reg <= 1'b0;
            ram_we_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (any_req) begin
                        owner_cpu_reg <= grant_cpu;
                        we_reg        <= grant_cpu ? cpu_we : dma_we;
                        ram_en_reg    <= 1'b1;
                        ram_we_reg    <= grant_cpu ? cpu_we : dma_we;
                        ram_addr_reg  <= grant_cpu ? cpu_addr : dma_addr;
                        ram_wdata_reg <= grant_cpu ? cpu_wdata : dma_wdata;
`ifndef MEM_ARB_CPU_PRIORITY_EN
                        last_dma_reg  <= !grant_cpu;
`endif
                        state_reg     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (we_reg) begin
                        state_reg <= S_ACK;
                    end else begin
                        cnt_reg   <= CNT_LOAD;
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Read data is only valid on the last counted cycle.
                    if (cnt_reg == '0) begin
                        if (owner_cpu_reg) begin
                            cpu_rdata_reg <= ram_rdata;
                        end else begin
                            dma_rdata_reg <= ram_rdata;
                        end
                        state_reg <= S_ACK;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_ack   = (state_reg == S_ACK) && owner_cpu_reg;
    assign dma_ack   = (state_reg == S_ACK) && !owner_cpu_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign dma_rdata = dma_rdata_reg;
    assign ram_en    = ram_en_reg;
    assign ram_we    = ram_we_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timeline model.
// Honours MEM_ARB_CPU_PRIORITY_EN in the model's arbitration rule.
module tb_mem_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int RL = 3;
    localparam int NC = 3000;
    localparam int MW = 1 << AW;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          cpu_req = 1'b0, dma_req = 1'b0;
    logic          cpu_we = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
    logic          cpu_ack, dma_ack, ram_en, ram_we, busy;
    logic [DW-1:0] cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    always #5 Clock = ~Clock;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .Clock(Clock), .Reset(Reset),
        .cpu_req(cpu_req), .dma_req(dma_req),
        .cpu_we(cpu_we), .dma_we(dma_we),
        .cpu_addr(cpu_addr), .dma_addr(dma_addr),
        .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
        .cpu_ack(cpu_ack), .dma_ack(dma_ack),
        .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata),
        .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    // RAM macro: read data valid RL cycles after the strobe, noise otherwise.
    logic [DW-1:0] mem [0:MW-1];
    logic [DW-1:0] rd_pipe [0:RL-1];
    always @(posedge Clock) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        rd_pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : $urandom();
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RL-1];

    // Expected per-cycle timeline built from transaction rules.
    bit            e_en [NC];
    bit            e_we [NC];
    logic [AW-1:0] e_addr [NC];
    logic [DW-1:0] e_wdata [NC];
    bit            e_cack [NC];
    bit            e_dack [NC];
    bit            e_busy [NC];
    bit            u_c [NC];
    bit            u_d [NC];
    logic [DW-1:0] u_cv [NC];
    logic [DW-1:0] u_dv [NC];
    logic [DW-1:0] ref_mem [0:MW-1];

    int            n_tests = 0;
    int            n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] a;
        case ($urandom_range(0, 4))
            0: a = '0;
            1: a = '1;
            2: a = AW'($urandom_range(1, 3));
            default: a = AW'($urandom());
        endcase
        return a;
    endfunction

    initial begin
        int            free_at;
        bit            last_dma;
        bit            rst_now;
        bit            rst_done;
        bit            w_cpu, w_we;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_wdata;
        logic [DW-1:0] cur_c, cur_d;
        int            ack_at, t_issue;
        bit            t_cpu, t_read;
        int            g_cpu, g_dma;

        for (int i = 0; i < MW; i++) begin
            mem[i]     = $urandom();
            ref_mem[i] = mem[i];
        end
        free_at = 0; last_dma = 1'b1; rst_done = 1'b0;
        cur_c = '0; cur_d = '0;
        t_issue = -100; t_cpu = 1'b0; t_read = 1'b0;
        g_cpu = 0; g_dma = 0;

        for (int c = 0; c < NC - 20; c++) begin
            @(negedge Clock);
            if (c >= 1) begin
                if (u_c[c]) cur_c = u_cv[c];
                if (u_d[c]) cur_d = u_dv[c];
                check_eq("ram_en", 64'(ram_en), 64'(e_en[c]));
                check_eq("ram_we", 64'(ram_we), 64'(e_en[c] & e_we[c]));
                if (e_en[c]) begin
                    check_eq("ram_addr", 64'(ram_addr), 64'(e_addr[c]));
                    if (e_we[c]) check_eq("ram_wdata", 64'(ram_wdata), 64'(e_wdata[c]));
                end
                check_eq("cpu_ack", 64'(cpu_ack), 64'(e_cack[c]));
                check_eq("dma_ack", 64'(dma_ack), 64'(e_dack[c]));
                check_eq("busy", 64'(busy), 64'(e_busy[c]));
                check_eq("cpu_rdata", 64'(cpu_rdata), 64'(cur_c));
                check_eq("dma_rdata", 64'(dma_rdata), 64'(cur_d));
                if (e_cack[c] || e_dack[c])
                    $display("[TB] cycle %0d ack %s rdata %08h", c, e_cack[c] ? "cpu" : "dma",
                             e_cack[c] ? cpu_rdata : dma_rdata);
            end

            // Requester behaviour for this cycle: hold until ack, then renew or drop.
            if (!cpu_req || e_cack[c]) begin
                if ($urandom_range(0, 99) < 55) begin
                    cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = pick_addr(); cpu_wdata = $urandom();
                end else cpu_req = 1'b0;
            end
            if (!dma_req || e_dack[c]) begin
                if ($urandom_range(0, 99) < 55) begin
                    dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
                    dma_addr = pick_addr(); dma_wdata = $urandom();
                end else dma_req = 1'b0;
            end

            // Reset at start, and once mid-run while a CPU read is waiting on RAM.
            rst_now = (c < 3);
            if (!rst_done && c > 1500 && t_cpu && t_read && c > t_issue && c <= t_issue + RL) begin
                rst_now = 1'b1;
                rst_done = 1'b1;
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = pick_addr();
                dma_req = 1'b1; dma_we = 1'b0; dma_addr = pick_addr();
                $display("[TB] cycle %0d reset during cpu read wait", c);
            end
            Reset = !rst_now;

            if (rst_now) begin
                for (int k = c + 1; k < NC; k++) begin
                    e_en[k] = 0; e_cack[k] = 0; e_dack[k] = 0; e_busy[k] = 0;
                    u_c[k] = 0; u_d[k] = 0;
                end
                u_c[c+1] = 1; u_cv[c+1] = '0;
                u_d[c+1] = 1; u_dv[c+1] = '0;
                free_at = c + 1; last_dma = 1'b1; t_cpu = 1'b0;
            end else if (c >= free_at && (cpu_req || dma_req)) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
                w_cpu = cpu_req;
`else
                w_cpu = cpu_req && (!dma_req || last_dma);
`endif
                last_dma = !w_cpu;
                w_we    = w_cpu ? cpu_we : dma_we;
                w_addr  = w_cpu ? cpu_addr : dma_addr;
                w_wdata = w_cpu ? cpu_wdata : dma_wdata;
                ack_at  = w_we ? c + 2 : c + 2 + RL;
                e_en[c+1] = 1; e_we[c+1] = w_we;
                e_addr[c+1] = w_addr; e_wdata[c+1] = w_wdata;
                for (int k = c + 1; k <= ack_at; k++) e_busy[k] = 1;
                if (w_cpu) e_cack[ack_at] = 1; else e_dack[ack_at] = 1;
                if (w_we) ref_mem[w_addr] = w_wdata;
                else if (w_cpu) begin u_c[ack_at] = 1; u_cv[ack_at] = ref_mem[w_addr]; end
                else begin u_d[ack_at] = 1; u_dv[ack_at] = ref_mem[w_addr]; end
                free_at = ack_at + 1;
                t_issue = c + 1; t_cpu = w_cpu; t_read = !w_we;
                if (w_cpu) g_cpu++; else g_dma++;
            end
        end

        check_eq("reset_in_wait_hit", 64'(rst_done), 64'd1);
        check_eq("cpu_grants_seen", 64'(g_cpu > 0), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
